md_issue_seq: RTL and testbench

// - Sequencing stage around the combinational 8-bit multiply and divide units in K_ALU.
// - Accepts an op request over valid/ready and registers the operands driven to the units.
// - Waits a fixed multicycle-path interval, then captures the selected unit's result.
// - Presents the captured result and flags to the consumer over valid/ready.

---
 rtl/md_issue_if.sv | 26 ++
 rtl/md_issue_seq.sv | 116 +++++++++++
 tb/tb_md_issue_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/md_issue_if.sv
// Request/response handshake bundle between a producer, md_issue_seq and its consumer.
// The master modport is the producer/consumer side, the slave modport is the sequencer.
interface md_issue_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic             in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_zero;
    logic             out_div0;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, out_zero, out_div0
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, out_zero, out_div0
    );
endinterface

// File: rtl/md_issue_seq.sv
// Issue/capture sequencer around combinational multiply and divide units (multicycle path).
// Optional feature: define MD_DIV0_TRAP_EN to short-circuit divide-by-zero without using the divider.
module md_issue_seq #(
    parameter int WIDTH       = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    md_issue_if.slave        bus,
    output logic [WIDTH-1:0] md_a,
    output logic [WIDTH-1:0] md_b,
    input  logic [WIDTH-1:0] mul_res,
    input  logic [WIDTH-1:0] div_res
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic             r_op;
    logic [WIDTH-1:0] r_md_a;
    logic [WIDTH-1:0] r_md_b;
    logic [WIDTH-1:0] r_out_res;
    logic             r_out_valid;
    logic             r_out_zero;
    logic             r_out_div0;

    logic             w_accept;
    logic             w_trap;
    logic [WIDTH-1:0] w_sel;

    function automatic logic f_is_zero(input logic [WIDTH-1:0] v);
        return (v == '0);
    endfunction

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_sel    = r_op ? div_res : mul_res;

`ifdef MD_DIV0_TRAP_EN
    assign w_trap = bus.in_op && f_is_zero(bus.in_b);
`else
    assign w_trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= 1'b0;
            r_md_a      <= '0;
            r_md_b      <= '0;
            r_out_res   <= '0;
            r_out_valid <= 1'b0;
            r_out_zero  <= 1'b0;
            r_out_div0  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= bus.in_op;
                        r_md_a <= bus.in_a;
                        r_md_b <= bus.in_b;
                        if (w_trap) begin
                            // Trapped divide-by-zero: result is synthesised here, the divider is never sampled.
                            r_out_res   <= '1;
                            r_out_zero  <= 1'b0;
                            r_out_div0  <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_cnt   <= CNT_LOAD;
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_out_res   <= w_sel;
                        r_out_zero  <= f_is_zero(w_sel);
                        r_out_div0  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_res   = r_out_res;
    assign bus.out_zero  = r_out_zero;
`ifdef MD_DIV0_TRAP_EN
    assign bus.out_div0  = r_out_div0;
`else
    assign bus.out_div0  = 1'b0;
`endif
    assign md_a = r_md_a;
    assign md_b = r_md_b;

endmodule

// File: tb/tb_md_issue_seq.sv
// Directed bench for md_issue_seq: transaction-level model plus literal expectations per scenario.
// Build with or without MD_DIV0_TRAP_EN to match the RTL build.
module tb_md_issue_seq;
    localparam int W  = 8;
    localparam int WC = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] md_a, md_b, mul_res, div_res;
    logic [15:0]  prod;

    int checks = 0;
    int errors = 0;

    md_issue_if #(.WIDTH(W)) bus ();

    md_issue_seq #(.WIDTH(W), .WAIT_CYCLES(WC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .md_a   (md_a),
        .md_b   (md_b),
        .mul_res(mul_res),
        .div_res(div_res)
    );

    always #5 clk = ~clk;

    // Combinational arithmetic units driven from the registered operands.
    assign prod    = 16'(md_a) * 16'(md_b);
    assign mul_res = prod[7:0];
    assign div_res = (md_b == 8'd0) ? 8'hFF : md_a / md_b;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one op in flight, result due a fixed number of cycles after accept.
    logic         m_busy = 1'b0;
    int           m_cyc = 0;
    int           m_vcyc = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic         m_zero = 1'b0, m_div0 = 1'b0;

    function automatic int exp_latency(input logic op, input logic [W-1:0] b);
`ifdef MD_DIV0_TRAP_EN
        if (op && b == 0) return 1;
`endif
        return WC + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic pre_valid;
        logic exp_v;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_a    = '0;
            m_b    = '0;
            m_cyc  = 0;
        end else begin
            pre_valid = m_busy && (m_cyc >= m_vcyc);
            if (!m_busy && bus.in_valid) begin
                m_busy = 1'b1;
                m_a    = bus.in_a;
                m_b    = bus.in_b;
                m_vcyc = m_cyc + exp_latency(bus.in_op, bus.in_b);
                if (!bus.in_op) m_res = 8'((16'(m_a) * 16'(m_b)) & 16'h00FF);
                else if (m_b == 0) m_res = 8'hFF;
                else m_res = m_a / m_b;
                m_zero = (m_res == 0);
                m_div0 = 1'b0;
`ifdef MD_DIV0_TRAP_EN
                if (bus.in_op && m_b == 0) begin
                    m_div0 = 1'b1;
                    m_zero = 1'b0;
                end
`endif
            end else if (pre_valid && bus.out_ready) begin
                m_busy = 1'b0;
            end
            m_cyc++;
        end
        #1;
        exp_v = m_busy && (m_cyc >= m_vcyc);
        chk("cmp_in_ready", int'(bus.in_ready), int'(!m_busy));
        chk("cmp_out_valid", int'(bus.out_valid), int'(exp_v));
        chk("cmp_md_a", int'(md_a), int'(m_a));
        chk("cmp_md_b", int'(md_b), int'(m_b));
        if (exp_v && bus.out_valid) begin
            chk("cmp_out_res", int'(bus.out_res), int'(m_res));
            chk("cmp_out_zero", int'(bus.out_zero), int'(m_zero));
            chk("cmp_out_div0", int'(bus.out_div0), int'(m_div0));
        end
    end

    task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input logic early, input int exp_lat,
                          input logic [W-1:0] exp_res, input logic exp_zero, input logic exp_div0);
        int n;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = early;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("md_a_latched", int'(md_a), int'(a));
        chk("md_b_latched", int'(md_b), int'(b));
        n = 1;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, exp_lat);
        chk("res", int'(bus.out_res), int'(exp_res));
        chk("zero", int'(bus.out_zero), int'(exp_zero));
        chk("div0", int'(bus.out_div0), int'(exp_div0));
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                if (i == 1) begin
                    bus.in_valid = 1'b1;
                    bus.in_op    = ~op;
                    bus.in_a     = a ^ 8'h5A;
                    bus.in_b     = 8'd3;
                end
                if (i == 3) bus.in_valid = 1'b0;
                @(negedge clk);
                chk("hold_valid", int'(bus.out_valid), 1);
                chk("hold_res", int'(bus.out_res), int'(exp_res));
                chk("hold_in_ready", int'(bus.in_ready), 0);
                chk("hold_md_a", int'(md_a), int'(a));
                chk("hold_md_b", int'(md_b), int'(b));
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("released_valid", int'(bus.out_valid), 0);
        chk("released_ready", int'(bus.in_ready), 1);
        chk("kept_md_a", int'(md_a), int'(a));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_md_a", int'(md_a), 0);
        chk("rst_md_b", int'(md_b), 0);
        chk("rst_out_res", int'(bus.out_res), 0);
        chk("rst_out_zero", int'(bus.out_zero), 0);
        chk("rst_out_div0", int'(bus.out_div0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 8'd12, 8'd10, 2, 1'b0, 3, 8'd120, 1'b0, 1'b0);
        run_op(1'b0, 8'd16, 8'd16, 1, 1'b0, 3, 8'd0, 1'b1, 1'b0);
        run_op(1'b1, 8'd200, 8'd7, 5, 1'b0, 3, 8'd28, 1'b0, 1'b0);
`ifdef MD_DIV0_TRAP_EN
        run_op(1'b1, 8'd9, 8'd0, 2, 1'b0, 1, 8'hFF, 1'b0, 1'b1);
`else
        run_op(1'b1, 8'd9, 8'd0, 2, 1'b0, 3, 8'hFF, 1'b0, 1'b0);
`endif
        run_op(1'b0, 8'd255, 8'd255, 0, 1'b0, 3, 8'd1, 1'b0, 1'b0);
        run_op(1'b1, 8'd255, 8'd16, 0, 1'b0, 3, 8'd15, 1'b0, 1'b0);
        run_op(1'b1, 8'd0, 8'd5, 0, 1'b0, 3, 8'd0, 1'b1, 1'b0);
        run_op(1'b0, 8'd3, 8'd5, 0, 1'b1, 3, 8'd15, 1'b0, 1'b0);

        // Abort an op while it is in EXEC.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 1'b0;
        bus.in_a     = 8'd7;
        bus.in_b     = 8'd9;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("abort_busy", int'(bus.in_ready), 0);
        rst_n = 1'b0;
        #2;
        chk("abort_in_ready", int'(bus.in_ready), 1);
        chk("abort_out_valid", int'(bus.out_valid), 0);
        chk("abort_md_a", int'(md_a), 0);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_valid", int'(bus.out_valid), 0);
        end
        run_op(1'b0, 8'd7, 8'd9, 1, 1'b0, 3, 8'd63, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
